median_frame_sequencer: RTL and testbench

Frame-level controller in front of `simpleMedianTop`. It accepts a stream of binary pixel events, clears the median block's input memory at the start of each frame and writes accepted events into it. When the collection window closes, it starts the median pass and waits for completion, counting median writes. It then emits a frame-done pulse and repeats while enabled.

---
 rtl/median_frame_sequencer_if.sv | 40 ++++
 rtl/median_frame_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_median_frame_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : median_frame_sequencer_if
// Description : Signal bundle between the frame sequencer, the pixel event
//               source and the median block.
//               master : sequencer side (accepts events, drives the median
//                        block's input-memory write port, start and threshold)
//               slave  : environment side (event source + median block)
// Signals     : evValid/evX/evY/evData/evReady - pixel event handshake
//               writeMem/xAddressIn/yAddressIn/dataIn - input-memory write port
//               start/fullImageDone/writeMedianMem - median pass control
//               threshold - threshold presented to the median block
// Revision    : 1.0 - initial release
// ============================================================================
interface median_frame_sequencer_if;
    logic        evValid;
    logic [7:0]  evX;
    logic [7:0]  evY;
    logic        evData;
    logic        evReady;
    logic        writeMem;
    logic [7:0]  xAddressIn;
    logic [7:0]  yAddressIn;
    logic        dataIn;
    logic        start;
    logic        fullImageDone;
    logic        writeMedianMem;
    logic [12:0] threshold;

    modport master (
        input  evValid, evX, evY, evData, fullImageDone, writeMedianMem,
        output evReady, writeMem, xAddressIn, yAddressIn, dataIn, start, threshold
    );

    modport slave (
        output evValid, evX, evY, evData, fullImageDone, writeMedianMem,
        input  evReady, writeMem, xAddressIn, yAddressIn, dataIn, start, threshold
    );
endinterface
`default_nettype wire

// File: rtl/median_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : median_frame_sequencer
// Description : Frame-level controller in front of the median block. Clears
//               the median input memory, collects pixel events for a fixed
//               window, runs the median pass (with timeout) and reports
//               frame completion. Repeats while enable is high.
// Ports       : clk, reset (sync, active-low), enable
//               cfgThreshold/cfgLoad - threshold shadow-register load
//               bus (master)         - event handshake + median block port
//               medianCount/dropCount/frameCount - statistics
//               frameDone/busy/timeoutErr        - status
// Revision    : 1.0 - initial release
// ============================================================================
module median_frame_sequencer #(
    parameter int WIDTH         = 240,
    parameter int HEIGHT        = 180,
    parameter int WINDOW_CYCLES = 100000,
    parameter int RUN_TIMEOUT   = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [12:0]              cfgThreshold,
    input  logic                     cfgLoad,
    median_frame_sequencer_if.master bus,
    output logic [15:0]              medianCount,
    output logic [15:0]              dropCount,
    output logic [15:0]              frameCount,
    output logic                     frameDone,
    output logic                     busy,
    output logic                     timeoutErr
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLEAR   = 3'd1;
    localparam logic [2:0] c_COLLECT = 3'd2;
    localparam logic [2:0] c_GAP     = 3'd3;
    localparam logic [2:0] c_RUN     = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    localparam int c_WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int c_RUN_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(RUN_TIMEOUT - 1);
    localparam logic [7:0]         c_LAST_X   = 8'(WIDTH - 1);
    localparam logic [7:0]         c_LAST_Y   = 8'(HEIGHT - 1);

    logic [2:0]         r_state;
    logic [12:0]        r_shadow;
    logic [12:0]        r_threshold;
    logic               r_evReady;
    logic               r_writeMem;
    logic [7:0]         r_xAddr;
    logic [7:0]         r_yAddr;
    logic               r_dataIn;
    logic               r_start;
    logic [c_WIN_W-1:0] r_winCnt;
    logic [c_RUN_W-1:0] r_runCnt;
    logic [15:0]        r_medianCount;
    logic [15:0]        r_dropCount;
    logic [15:0]        r_frameCount;
    logic               r_frameDone;
    logic               r_busy;
    logic               r_timeoutErr;

    logic w_handshake;
    logic w_inRange;
    logic w_enterClear;

    // evReady is only ever high in COLLECT, but the state term keeps the
    // intent explicit.
    assign w_handshake  = (r_state == c_COLLECT) && bus.evValid && r_evReady;
    // Widened compare so WIDTH/HEIGHT of 256 remain representable.
    assign w_inRange    = ({1'b0, bus.evX} < 9'(WIDTH)) && ({1'b0, bus.evY} < 9'(HEIGHT));
    assign w_enterClear = enable && ((r_state == c_IDLE) || (r_state == c_DONE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_shadow      <= 13'd0;
            r_threshold   <= 13'd0;
            r_evReady     <= 1'b0;
            r_writeMem    <= 1'b0;
            r_xAddr       <= 8'd0;
            r_yAddr       <= 8'd0;
            r_dataIn      <= 1'b0;
            r_start       <= 1'b0;
            r_winCnt      <= '0;
            r_runCnt      <= '0;
            r_medianCount <= 16'd0;
            r_dropCount   <= 16'd0;
            r_frameCount  <= 16'd0;
            r_frameDone   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeoutErr  <= 1'b0;
        end else begin
            if (cfgLoad) begin
                r_shadow <= cfgThreshold;
            end
            r_frameDone <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_evReady  <= 1'b0;
                    r_writeMem <= 1'b0;
                    r_start    <= 1'b0;
                end

                c_CLEAR: begin
                    // r_xAddr/r_yAddr hold the address being written this clock.
                    if ((r_xAddr == c_LAST_X) && (r_yAddr == c_LAST_Y)) begin
                        r_writeMem <= 1'b0;
                        r_evReady  <= 1'b1;
                        r_winCnt   <= '0;
                        r_state    <= c_COLLECT;
                    end else begin
                        r_writeMem <= 1'b1;
                        r_dataIn   <= 1'b0;
                        if (r_yAddr == c_LAST_Y) begin
                            r_yAddr <= 8'd0;
                            r_xAddr <= r_xAddr + 8'd1;
                        end else begin
                            r_yAddr <= r_yAddr + 8'd1;
                        end
                    end
                end

                c_COLLECT: begin
                    r_writeMem <= 1'b0;
                    if (w_handshake) begin
                        if (w_inRange) begin
                            r_writeMem <= 1'b1;
                            r_xAddr    <= bus.evX;
                            r_yAddr    <= bus.evY;
                            r_dataIn   <= bus.evData;
                        end else if (r_dropCount != 16'hFFFF) begin
                            r_dropCount <= r_dropCount + 16'd1;
                        end
                    end
                    // A handshake on the final window clock is still written,
                    // landing in the GAP clock.
                    if (r_winCnt == c_WIN_LAST) begin
                        r_evReady <= 1'b0;
                        r_state   <= c_GAP;
                    end else begin
                        r_winCnt <= r_winCnt + 1'b1;
                    end
                end

                c_GAP: begin
                    r_writeMem    <= 1'b0;
                    r_start       <= 1'b1;
                    r_medianCount <= 16'd0;
                    r_runCnt      <= '0;
                    r_state       <= c_RUN;
                end

                c_RUN: begin
                    // A strobe coincident with completion is still counted.
                    if (bus.writeMedianMem && (r_medianCount != 16'hFFFF)) begin
                        r_medianCount <= r_medianCount + 16'd1;
                    end
                    if (bus.fullImageDone || (r_runCnt == c_RUN_LAST)) begin
                        if (!bus.fullImageDone) begin
                            r_timeoutErr <= 1'b1;
                        end
                        r_start      <= 1'b0;
                        r_frameDone  <= 1'b1;
                        r_frameCount <= r_frameCount + 16'd1;
                        r_state      <= c_DONE;
                    end else begin
                        r_runCnt <= r_runCnt + 1'b1;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Frame start from IDLE or DONE. r_shadow here is the pre-edge
            // value, so a coincident cfgLoad only reaches the next frame.
            if (w_enterClear) begin
                r_state     <= c_CLEAR;
                r_busy      <= 1'b1;
                r_threshold <= r_shadow;
                r_dropCount <= 16'd0;
                r_writeMem  <= 1'b1;
                r_xAddr     <= 8'd0;
                r_yAddr     <= 8'd0;
                r_dataIn    <= 1'b0;
            end
        end
    end

    assign bus.evReady    = r_evReady;
    assign bus.writeMem   = r_writeMem;
    assign bus.xAddressIn = r_xAddr;
    assign bus.yAddressIn = r_yAddr;
    assign bus.dataIn     = r_dataIn;
    assign bus.start      = r_start;
    assign bus.threshold  = r_threshold;
    assign medianCount    = r_medianCount;
    assign dropCount      = r_dropCount;
    assign frameCount     = r_frameCount;
    assign frameDone      = r_frameDone;
    assign busy           = r_busy;
    assign timeoutErr     = r_timeoutErr;

endmodule
`default_nettype wire

// File: tb/tb_median_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_median_frame_sequencer
// Description : Self-checking bench for median_frame_sequencer. Stimulus pushes
//               expected memory writes and per-frame results into queues; a
//               monitor pops and compares whenever writeMem or frameDone fire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_frame_sequencer;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int WIN = 8;
    localparam int TO  = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [12:0] cfgThreshold;
    logic        cfgLoad;
    logic [15:0] medianCount;
    logic [15:0] dropCount;
    logic [15:0] frameCount;
    logic        frameDone;
    logic        busy;
    logic        timeoutErr;

    median_frame_sequencer_if bus();

    median_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .WINDOW_CYCLES(WIN), .RUN_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfgThreshold(cfgThreshold), .cfgLoad(cfgLoad),
        .bus(bus),
        .medianCount(medianCount), .dropCount(dropCount), .frameCount(frameCount),
        .frameDone(frameDone), .busy(busy), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       d;
    } wr_t;

    typedef struct packed {
        logic [15:0] med;
        logic [15:0] drop;
        logic [15:0] frames;
        logic        tErr;
        logic [12:0] thr;
    } frm_t;

    wr_t  wrQ[$];
    frm_t frmQ[$];

    int nVec  = 0;
    int nFail = 0;

    // Reference model state
    logic [12:0] mShadow;
    logic [12:0] mThr;
    int          mFrames;
    logic        mTErr;

    always @(posedge clk) begin
        if (!reset)       mShadow <= 13'd0;
        else if (cfgLoad) mShadow <= cfgThreshold;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard comparisons on DUT output events
    always @(negedge clk) begin
        wr_t  e;
        frm_t f;
        if (reset) begin
            if (bus.writeMem) begin
                if (wrQ.size() == 0) begin
                    nVec++;
                    nFail++;
                    $display("FAIL unexpected_write: got x=%0d y=%0d d=%0d, expected no write",
                             bus.xAddressIn, bus.yAddressIn, bus.dataIn);
                end else begin
                    e = wrQ.pop_front();
                    chk("wr_x", bus.xAddressIn, e.x);
                    chk("wr_y", bus.yAddressIn, e.y);
                    chk("wr_data", bus.dataIn, e.d);
                end
            end
            if (frameDone) begin
                if (frmQ.size() == 0) begin
                    nVec++;
                    nFail++;
                    $display("FAIL unexpected_frameDone: got pulse, expected none");
                end else begin
                    f = frmQ.pop_front();
                    chk("frm_medianCount", medianCount, f.med);
                    chk("frm_dropCount", dropCount, f.drop);
                    chk("frm_frameCount", frameCount, f.frames);
                    chk("frm_timeoutErr", timeoutErr, f.tErr);
                    chk("frm_threshold", bus.threshold, f.thr);
                end
            end
        end
    end

    // kind 0: directed events, 7 median writes then done
    // kind 1: random events, median pass never completes (timeout)
    // kind 2: random events, done with coincident write, enable dropped in RUN
    task automatic runFrame(input int kind);
        int   drop    = 0;
        int   med     = 0;
        bit   pendWr  = 0;
        bit   inRange;
        bit   fid;
        bit   wmm;
        bit   done;
        int   fidAt   = $urandom_range(5, 15);

        mThr = mShadow;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                wrQ.push_back('{x: 8'(x), y: 8'(y), d: 1'b0});

        tick();  // CLEAR entry
        cfgLoad = 1'b0;
        chk("clear_busy", busy, 1);
        chk("clear_threshold", bus.threshold, mThr);
        chk("clear_evReady", bus.evReady, 0);
        chk("clear_dropCount", dropCount, 0);
        repeat (W * H) tick();

        for (int c = 0; c < WIN; c++) begin
            chk("collect_evReady", bus.evReady, 1);
            chk("collect_wr_latency", bus.writeMem, pendWr);
            if (kind == 0) begin
                bus.evValid = 1'b0;
                case (c)
                    0: begin bus.evValid = 1'b1; bus.evX = 8'd1; bus.evY = 8'd2; bus.evData = 1'b1; end
                    2: begin bus.evValid = 1'b1; bus.evX = 8'd5; bus.evY = 8'd0; bus.evData = 1'b1; end
                    4: begin bus.evValid = 1'b1; bus.evX = 8'd3; bus.evY = 8'd1; bus.evData = 1'b0; end
                    default: ;
                endcase
                cfgLoad      = (c == 3);
                cfgThreshold = 13'd50;
            end else begin
                bus.evValid        = ($urandom_range(0, 9) < 7);
                bus.evX            = 8'($urandom_range(0, 6));
                bus.evY            = 8'($urandom_range(0, 4));
                bus.evData         = 1'($urandom_range(0, 1));
                bus.fullImageDone  = 1'($urandom_range(0, 1));
                bus.writeMedianMem = 1'($urandom_range(0, 1));
            end
            inRange = (int'(bus.evX) < W) && (int'(bus.evY) < H);
            pendWr  = bus.evValid && inRange;
            if (bus.evValid) begin
                if (inRange) wrQ.push_back('{x: bus.evX, y: bus.evY, d: bus.evData});
                else         drop++;
            end
            tick();
        end
        bus.evValid        = 1'b0;
        bus.fullImageDone  = 1'b0;
        bus.writeMedianMem = 1'b0;
        cfgLoad            = 1'b0;

        // GAP clock
        chk("gap_evReady", bus.evReady, 0);
        chk("gap_writeMem", bus.writeMem, pendWr);
        chk("gap_start", bus.start, 0);
        chk("gap_dropCount", dropCount, drop);
        chk("gap_threshold_held", bus.threshold, mThr);
        tick();

        for (int j = 1; j <= TO; j++) begin
            chk("run_start", bus.start, 1);
            chk("run_writeMem", bus.writeMem, 0);
            case (kind)
                0: begin wmm = (j <= 7); fid = (j == 8); end
                1: begin wmm = 1'($urandom_range(0, 1)); fid = 1'b0; end
                default: begin
                    fid = (j == fidAt);
                    wmm = fid ? 1'b1 : 1'($urandom_range(0, 1));
                    if (j == 3) enable = 1'b0;
                end
            endcase
            bus.writeMedianMem = wmm;
            bus.fullImageDone  = fid;
            if (wmm) med++;
            done = fid || (j == TO);
            if (done) begin
                frmQ.push_back('{med: 16'(med), drop: 16'(drop), frames: 16'(mFrames + 1),
                                 tErr: mTErr | !fid, thr: mThr});
                if (!fid) mTErr = 1'b1;
                mFrames++;
            end
            tick();
            if (done) break;
        end
        bus.writeMedianMem = 1'b0;
        bus.fullImageDone  = 1'b0;

        // DONE clock
        chk("done_start", bus.start, 0);
        chk("done_frameDone", frameDone, 1);
        chk("done_frameCount", frameCount, 16'(mFrames));
        chk("done_medianCount", medianCount, 16'(med));
    endtask

    initial begin
        reset              = 1'b0;
        enable             = 1'b0;
        cfgThreshold       = 13'd0;
        cfgLoad            = 1'b0;
        bus.evValid        = 1'b0;
        bus.evX            = 8'd0;
        bus.evY            = 8'd0;
        bus.evData         = 1'b0;
        bus.fullImageDone  = 1'b0;
        bus.writeMedianMem = 1'b0;
        mFrames            = 0;
        mTErr              = 1'b0;
        mThr               = 13'd0;
        repeat (3) tick();
        reset = 1'b1;

        chk("rst_busy", busy, 0);
        chk("rst_evReady", bus.evReady, 0);
        chk("rst_writeMem", bus.writeMem, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_threshold", bus.threshold, 0);
        chk("rst_frameCount", frameCount, 0);
        chk("rst_timeoutErr", timeoutErr, 0);

        // Load 17 while idle; the first frame must use it
        cfgThreshold = 13'd17;
        cfgLoad      = 1'b1;
        tick();
        cfgLoad = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_threshold_unchanged", bus.threshold, 0);

        enable = 1'b1;
        runFrame(0);
        chk("f1_dropCount", dropCount, 1);
        chk("f1_timeoutErr", timeoutErr, 0);

        runFrame(1);
        chk("f2_timeoutErr", timeoutErr, 1);

        // cfgLoad coincident with CLEAR entry: old shadow (50) used this frame
        cfgThreshold = 13'd99;
        cfgLoad      = 1'b1;
        runFrame(2);
        chk("f3_timeoutErr_sticky", timeoutErr, 1);
        tick();
        chk("after_disable_busy", busy, 0);
        chk("after_disable_start", bus.start, 0);
        repeat (3) tick();
        chk("idle_hold_busy", busy, 0);
        chk("idle_hold_frameCount", frameCount, 16'(mFrames));
        chk("idle_hold_threshold", bus.threshold, 50);

        // Start a frame and reset it mid-CLEAR
        mThr = mShadow;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                wrQ.push_back('{x: 8'(x), y: 8'(y), d: 1'b0});
        enable = 1'b1;
        tick();
        chk("f4_threshold", bus.threshold, 99);
        repeat (4) tick();
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        reset = 1'b1;
        wrQ.delete();
        mFrames = 0;
        mTErr   = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_writeMem", bus.writeMem, 0);
        chk("mid_rst_xAddressIn", bus.xAddressIn, 0);
        chk("mid_rst_yAddressIn", bus.yAddressIn, 0);
        chk("mid_rst_dataIn", bus.dataIn, 0);
        chk("mid_rst_threshold", bus.threshold, 0);
        chk("mid_rst_timeoutErr", timeoutErr, 0);
        chk("mid_rst_frameCount", frameCount, 0);
        chk("mid_rst_medianCount", medianCount, 0);
        chk("mid_rst_dropCount", dropCount, 0);
        tick();
        chk("post_rst_idle_busy", busy, 0);

        // One more random frame from a clean reset
        enable = 1'b1;
        runFrame(2);
        chk("f5_timeoutErr", timeoutErr, 0);
        tick();
        chk("f5_idle_busy", busy, 0);

        repeat (2) tick();
        chk("wrQ_drained", wrQ.size(), 0);
        chk("frmQ_drained", frmQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
